// File: rtl/barcode_2of5_reader.sv
// Industrial 2-of-5 symbol reader: frames start..stop, decodes and buffers
// digits, optionally verifies a mod-10 check digit, reports done/error.
module barcode_2of5_reader #(
  parameter int unsigned MAX_DIGITS = 10,
  parameter bit          CHK_EN     = 1'b1,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [4:0]  START_SYM  = 5'b11011,
  parameter logic [4:0]  STOP_SYM   = 5'b11101,
  localparam int unsigned CW        = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clock,
  input  logic                    I_StateMachine_Reset,
  input  logic                    PG,
  input  logic [4:0]              I,
  input  logic                    I_Valid,
  output logic                    FIM,
  output logic                    DEZ,
  output logic                    DOIS,
  output logic                    O_Error,
  output logic [3:0]              O_Digit,
  output logic                    O_DigitValid,
  output logic [CW-1:0]           O_Count,
  output logic [4*MAX_DIGITS-1:0] O_Digits
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned IW = (MAX_DIGITS > 1) ? $clog2(4 * MAX_DIGITS) : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DIGITS,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [3:0]    sum;
  logic [3:0]    prev_sum;
  logic [TW-1:0] timer;

  logic [2:0]    sym_ones;
  logic [3:0]    sym_raw;
  logic [3:0]    sym_digit;
  logic          sym_ok;
  logic [4:0]    sum_wide;
  logic [3:0]    sum_next;
  logic [IW-1:0] wr_idx;

  // Symbol decode: two-of-five check and weighted value (1,2,4,7,0; 11 -> 0)
  always_comb begin
    sym_ones  = 3'(I[0]) + 3'(I[1]) + 3'(I[2]) + 3'(I[3]) + 3'(I[4]);
    sym_ok    = (sym_ones == 3'd2);
    sym_raw   = (I[4] ? 4'd1 : 4'd0) + (I[3] ? 4'd2 : 4'd0)
              + (I[2] ? 4'd4 : 4'd0) + (I[1] ? 4'd7 : 4'd0);
    sym_digit = (sym_raw == 4'd11) ? 4'd0 : sym_raw;
    sum_wide  = 5'(sum) + 5'(sym_digit);
    sum_next  = (sum_wide >= 5'd10) ? 4'(sum_wide - 5'd10) : sum_wide[3:0];
    wr_idx    = IW'({O_Count, 2'b00});
  end

  // Reader FSM with registered outputs, buffer, running sums and idle timer
  always_ff @(posedge clock or negedge I_StateMachine_Reset) begin
    if (!I_StateMachine_Reset) begin
      state        <= S_IDLE;
      sum          <= '0;
      prev_sum     <= '0;
      timer        <= '0;
      FIM          <= 1'b0;
      DEZ          <= 1'b0;
      DOIS         <= 1'b0;
      O_Error      <= 1'b0;
      O_Digit      <= '0;
      O_DigitValid <= 1'b0;
      O_Count      <= '0;
      O_Digits     <= '0;
    end else begin
      O_DigitValid <= 1'b0;
      if (!PG) begin
        // Abort: buffer is kept for the host, everything else drops
        if (state != S_IDLE) begin
          state   <= S_IDLE;
          O_Count <= '0;
          DEZ     <= 1'b0;
          FIM     <= 1'b0;
          O_Error <= 1'b0;
          timer   <= '0;
        end
      end else begin
        if (I_Valid && (state != S_IDLE)) begin
          DOIS <= sym_ok;
        end
        case (state)
          S_IDLE: state <= S_WAIT_START;
          S_WAIT_START: begin
            if (I_Valid && (I == START_SYM)) begin
              state    <= S_DIGITS;
              O_Count  <= '0;
              DEZ      <= 1'b0;
              sum      <= '0;
              prev_sum <= '0;
              timer    <= '0;
              O_Digits <= '0;
            end
          end
          S_DIGITS: begin
            if (I_Valid) begin
              timer <= '0;
              if (I == STOP_SYM) begin
                if (CHK_EN) begin
                  if (32'(O_Count) >= 32'd2) begin
                    state <= S_CHECK;
                  end else begin
                    state   <= S_ERROR;
                    O_Error <= 1'b1;
                  end
                end else if (32'(O_Count) >= 32'd1) begin
                  state <= S_DONE;
                  FIM   <= 1'b1;
                end else begin
                  state   <= S_ERROR;
                  O_Error <= 1'b1;
                end
              end else if (sym_ok && (32'(O_Count) < MAX_DIGITS)) begin
                O_Digits[wr_idx +: 4] <= sym_digit;
                O_Count               <= O_Count + 1'b1;
                DEZ                   <= (32'(O_Count) + 32'd1 == MAX_DIGITS);
                prev_sum              <= sum;
                sum                   <= sum_next;
                O_Digit               <= sym_digit;
                O_DigitValid          <= 1'b1;
              end else begin
                // Bad symbol, misplaced start, or buffer overflow
                state   <= S_ERROR;
                O_Error <= 1'b1;
              end
            end else if (timer == TW'(TIMEOUT - 1)) begin
              state   <= S_ERROR;
              O_Error <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_CHECK: begin
            // Sum of all digits before the last must equal the last (mod 10)
            if (prev_sum == O_Digit) begin
              state <= S_DONE;
              FIM   <= 1'b1;
            end else begin
              state   <= S_ERROR;
              O_Error <= 1'b1;
            end
          end
          S_DONE, S_ERROR: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_barcode_2of5_reader.sv
// Directed bench: dut_a checks the mod-10 digit with an 8-cycle timeout,
// dut_b has no check digit; both see the same symbol stream.
module tb_barcode_2of5_reader;

  localparam logic [4:0] START = 5'b11011;
  localparam logic [4:0] STOP  = 5'b11101;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        PG;
  logic [4:0]  I;
  logic        I_Valid;

  logic        fim_a, dez_a, dois_a, err_a, dv_a;
  logic [3:0]  dig_a, cnt_a;
  logic [39:0] digits_a;
  logic        fim_b, dez_b, dois_b, err_b, dv_b;
  logic [3:0]  dig_b, cnt_b;
  logic [39:0] digits_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  barcode_2of5_reader #(
    .MAX_DIGITS(10), .CHK_EN(1'b1), .TIMEOUT(8),
    .START_SYM(START), .STOP_SYM(STOP)
  ) dut_a (
    .clock(clock), .I_StateMachine_Reset(rst_n), .PG(PG), .I(I), .I_Valid(I_Valid),
    .FIM(fim_a), .DEZ(dez_a), .DOIS(dois_a), .O_Error(err_a), .O_Digit(dig_a),
    .O_DigitValid(dv_a), .O_Count(cnt_a), .O_Digits(digits_a)
  );

  barcode_2of5_reader #(
    .MAX_DIGITS(10), .CHK_EN(1'b0), .TIMEOUT(255),
    .START_SYM(START), .STOP_SYM(STOP)
  ) dut_b (
    .clock(clock), .I_StateMachine_Reset(rst_n), .PG(PG), .I(I), .I_Valid(I_Valid),
    .FIM(fim_b), .DEZ(dez_b), .DOIS(dois_b), .O_Error(err_b), .O_Digit(dig_b),
    .O_DigitValid(dv_b), .O_Count(cnt_b), .O_Digits(digits_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given strobe/symbol; returns 1 time unit after it
  task automatic tick(input logic v, input logic [4:0] s);
    I_Valid = v;
    I       = s;
    @(posedge clock);
    #1;
  endtask

  task automatic restart();
    PG = 1'b0;
    tick(1'b0, 5'b0);
    PG = 1'b1;
    tick(1'b0, 5'b0);
    tick(1'b1, START);
  endtask

  initial begin
    rst_n = 1'b0; PG = 1'b0; I = '0; I_Valid = 1'b0;
    #12;
    chk("rst_fim", fim_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_digits", digits_a, 0);
    chk("rst_dois", dois_b, 0);
    rst_n = 1'b1;

    // Good frame 1,2,3,6 (check digit 6 = 1+2+3)
    PG = 1'b1;
    tick(1'b0, 5'b0);
    tick(1'b1, START);
    chk("start_dois", dois_a, 0);
    chk("start_cnt", cnt_a, 0);
    tick(1'b1, 5'b10001);
    chk("d1_dv", dv_a, 1);
    chk("d1_dig", dig_a, 1);
    chk("d1_dois", dois_a, 1);
    tick(1'b1, 5'b01001);
    chk("d2_dig", dig_a, 2);
    tick(1'b1, 5'b11000);
    chk("d3_dig", dig_a, 3);
    chk("d3_cnt", cnt_a, 3);
    tick(1'b1, 5'b01100);
    chk("d4_dig", dig_a, 6);
    chk("d4_dv", dv_a, 1);
    chk("d4_dois", dois_a, 1);
    chk("d4_cnt", cnt_a, 4);
    tick(1'b1, STOP);
    chk("stop_fim_a", fim_a, 0);
    chk("stop_fim_b", fim_b, 1);
    chk("stop_dv", dv_a, 0);
    tick(1'b0, 5'b0);
    chk("chk_fim_a", fim_a, 1);
    chk("chk_err_a", err_a, 0);
    chk("chk_digits", digits_a[15:0], 16'h6321);
    chk("chk_cnt", cnt_a, 4);
    PG = 1'b0;
    tick(1'b0, 5'b0);
    chk("pg_fim", fim_a, 0);
    chk("pg_cnt", cnt_a, 0);
    chk("pg_buf_kept", digits_a[15:0], 16'h6321);

    // Bad check digit 1,2,3,5
    PG = 1'b1;
    tick(1'b0, 5'b0);
    tick(1'b1, START);
    chk("start_clr_buf", digits_a, 0);
    tick(1'b1, 5'b10001);
    tick(1'b1, 5'b01001);
    tick(1'b1, 5'b11000);
    tick(1'b1, 5'b10100);
    chk("d5_dig", dig_a, 5);
    tick(1'b1, STOP);
    chk("bad_stop_err_a", err_a, 0);
    chk("bad_stop_fim_b", fim_b, 1);
    tick(1'b0, 5'b0);
    chk("bad_err_a", err_a, 1);
    chk("bad_fim_a", fim_a, 0);
    PG = 1'b0;
    tick(1'b0, 5'b0);
    chk("bad_pg_err", err_a, 0);

    // Invalid symbol 10101
    restart();
    tick(1'b1, 5'b10101);
    chk("inv_dois", dois_a, 0);
    chk("inv_err", err_a, 1);
    chk("inv_cnt", cnt_a, 0);
    chk("inv_dv", dv_a, 0);
    tick(1'b1, 5'b10001);
    chk("err_ign_cnt", cnt_a, 0);
    chk("err_ign_dv", dv_a, 0);
    chk("err_dois", dois_a, 1);

    // Fill to MAX_DIGITS, then overflow
    restart();
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 5'b00110);
      if (k == 8) chk("fill9_dez", dez_b, 0);
    end
    chk("fill_dez", dez_b, 1);
    chk("fill_cnt", cnt_b, 10);
    chk("fill_dig", dig_b, 0);
    tick(1'b1, 5'b00110);
    chk("ovf_err_b", err_b, 1);
    chk("ovf_err_a", err_a, 1);
    chk("ovf_cnt", cnt_b, 10);

    // Full buffer then stop
    restart();
    for (int k = 0; k < 10; k++) tick(1'b1, 5'b00110);
    tick(1'b1, STOP);
    chk("full_stop_fim_b", fim_b, 1);
    chk("full_stop_fim_a", fim_a, 0);
    chk("full_stop_err_b", err_b, 0);
    tick(1'b0, 5'b0);
    chk("full_chk_fim_a", fim_a, 1);

    // Timeout: 8 idle cycles after last strobe
    restart();
    tick(1'b1, 5'b10001);
    for (int k = 0; k < 7; k++) tick(1'b0, 5'b0);
    chk("to7_err", err_a, 0);
    tick(1'b0, 5'b0);
    chk("to8_err_a", err_a, 1);
    chk("to8_err_b", err_b, 0);

    // 7 idle cycles then a digit keeps the frame alive and rearms the timer
    restart();
    tick(1'b1, 5'b10001);
    for (int k = 0; k < 7; k++) tick(1'b0, 5'b0);
    tick(1'b1, 5'b01001);
    chk("to_rearm_dv", dv_a, 1);
    chk("to_rearm_err", err_a, 0);
    chk("to_rearm_cnt", cnt_a, 2);
    for (int k = 0; k < 7; k++) tick(1'b0, 5'b0);
    chk("to_rearm7_err", err_a, 0);
    tick(1'b0, 5'b0);
    chk("to_rearm8_err", err_a, 1);

    // PG drop on the same edge as a strobe
    restart();
    tick(1'b1, 5'b10001);
    PG = 1'b0;
    tick(1'b1, 5'b01001);
    chk("pgdrop_dv", dv_a, 0);
    chk("pgdrop_cnt", cnt_a, 0);
    chk("pgdrop_dig", dig_a, 1);

    // Asynchronous reset mid-frame
    PG = 1'b1;
    tick(1'b0, 5'b0);
    tick(1'b1, START);
    tick(1'b1, 5'b10001);
    chk("pre_rst_dv", dv_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dv", dv_a, 0);
    chk("arst_cnt", cnt_a, 0);
    chk("arst_dig", dig_a, 0);
    chk("arst_dois", dois_a, 0);
    chk("arst_digits", digits_a, 0);
    rst_n = 1'b1;
    tick(1'b1, 5'b10001);
    chk("idle_dois", dois_a, 0);
    tick(1'b1, 5'b10001);
    chk("ws_ign_dv", dv_a, 0);
    chk("ws_ign_cnt", cnt_a, 0);
    chk("ws_dois", dois_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
